wb_write_arbiter: RTL

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_write_arbiter_pkg.sv | 24 ++
 rtl/llu_result_fifo.sv | 81 ++++++++
 rtl/wb_write_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared register/value types, the LLU result entry, and default sizing for
// the writeback arbiter.
package wb_write_arbiter_pkg;

    typedef logic [4:0]  reg_t;
    typedef logic [31:0] val_t;

    localparam int DEPTH_DEFAULT        = 2;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef struct packed {
        reg_t rd;
        val_t val;
    } llu_entry_t;

    // x0 is hardwired, so it never counts as a pending destination
    function automatic logic [31:0] rd_onehot(input reg_t rd);
        logic [31:0] mask;
        mask = '0;
        if (rd != '0) mask[rd] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/llu_result_fifo.sv
// Circular FIFO of long-latency-unit results with a registered busy mask of
// the destination registers still waiting to be written.
module llu_result_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  llu_entry_t  push_entry,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output llu_entry_t  head,
    output logic [31:0] busy_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    llu_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_valid_next;
    logic [31:0]      busy_q;
    logic [31:0]      busy_next;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !rst;
    assign do_pop    = pop && !empty && !rst;
    assign head      = mem[head_ptr];
    assign busy_mask = busy_q;

    // Mask is rebuilt from the post-edge slot contents so it lands with the data
    always_comb begin
        slot_valid_next = slot_valid;
        busy_next       = '0;
        if (do_pop)  slot_valid_next[head_ptr] = 1'b0;
        if (do_push) slot_valid_next[tail_ptr] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid_next[i]) begin
                if (do_push && (tail_ptr == PTR_W'(i)))
                    busy_next = busy_next | rd_onehot(push_entry.rd);
                else
                    busy_next = busy_next | rd_onehot(mem[i].rd);
            end
        end
    end

    // Pointers wrap for free because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            slot_valid <= '0;
            busy_q     <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + 1'b1;
            if (do_pop)  head_ptr <= head_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            slot_valid <= slot_valid_next;
            busy_q     <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= push_entry;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the single register-file write port between the writeback stage and
// buffered LLU results, stalling the pipeline when an LLU result starves.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeValid,
    input  reg_t        pipeRd,
    input  val_t        pipeRdVal,
    output logic        pipeStall,
    input  logic        lluValid,
    input  reg_t        lluRd,
    input  val_t        lluRdVal,
    output logic        lluReady,
    output logic        wrEn,
    output reg_t        wrAddr,
    output val_t        wrVal,
    output logic [31:0] busyMask
);

    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        pipe_owns;
    logic        head_owns;
    llu_entry_t  push_entry;
    llu_entry_t  head_entry;
    logic [31:0] fifo_busy;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;

    assign push_entry = '{rd: lluRd, val: lluRdVal};

    // Ready looks only at registered occupancy; a pop this cycle does not free a slot early
    assign lluReady  = rst || !fifo_full;
    assign push      = lluValid && !fifo_full && !rst;
    assign pipeStall = !rst && !fifo_empty && (starve_q == 4'(STARVE_LIMIT));
    assign pipe_owns = !rst && pipeValid && !pipeStall;
    assign head_owns = !rst && !pipe_owns && !fifo_empty;
    assign pop       = head_owns;
    assign busyMask  = rst ? '0 : fifo_busy;

    llu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head_entry),
        .busy_mask  (fifo_busy)
    );

    // A popped head targeting x0 is dropped silently; the port then mirrors the pipeline
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = pipeRd;
        wrVal  = pipeRdVal;
        if (pipe_owns) begin
            wrEn = (pipeRd != '0);
        end else if (head_owns && (head_entry.rd != '0)) begin
            wrEn   = 1'b1;
            wrAddr = head_entry.rd;
            wrVal  = head_entry.val;
        end
    end

    always_comb begin
        starve_d = starve_q + 4'd1;
        if (fifo_empty || pop) starve_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

endmodule
